// File: rtl/paddle_controller_if.sv
// paddle_controller_if
//   Groups the paddle controller's inputs (frame tick, debounced button
//   pulses and levels) and its registered outputs (position, moving flag,
//   limit flag) into one bundle.
//   slave  : the paddle controller itself (consumes buttons, drives outputs).
//   master : the upstream/downstream environment (drives buttons, reads outputs).
interface paddle_controller_if #(
    parameter int unsigned WIDTH = 10
);
    logic             frame_tick_in;
    logic             up_press_in;
    logic             up_level_in;
    logic             down_press_in;
    logic             down_level_in;
    logic [WIDTH-1:0] paddle_y_out;
    logic             moving_out;
    logic             at_limit_out;

    modport slave (
        input  frame_tick_in,
        input  up_press_in,
        input  up_level_in,
        input  down_press_in,
        input  down_level_in,
        output paddle_y_out,
        output moving_out,
        output at_limit_out
    );

    modport master (
        output frame_tick_in,
        output up_press_in,
        output up_level_in,
        output down_press_in,
        output down_level_in,
        input  paddle_y_out,
        input  moving_out,
        input  at_limit_out
    );
endinterface

// File: rtl/paddle_controller.sv
// paddle_controller
//   Turns debounced up/down button pulses and levels into a saturating
//   paddle vertical position. A press steps immediately; holding the button
//   auto-repeats on frame ticks after a hold delay.
//   clock_in : system clock
//   reset_in : synchronous, active-high reset
//   bus      : paddle_controller_if.slave
//              in : frame_tick_in, up_press_in, up_level_in,
//                   down_press_in, down_level_in
//              out: paddle_y_out, moving_out, at_limit_out (all registered)
module paddle_controller #(
    parameter int unsigned WIDTH         = 10,
    parameter int unsigned Y_MIN         = 0,
    parameter int unsigned Y_MAX         = 400,
    parameter int unsigned Y_INIT        = 200,
    parameter int unsigned STEP          = 4,
    parameter int unsigned HOLD_DELAY    = 30,
    parameter int unsigned REPEAT_PERIOD = 2
) (
    input  logic                clock_in,
    input  logic                reset_in,
    paddle_controller_if.slave  bus
);
    localparam int unsigned CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]    HOLD_CNT   = CW'(HOLD_DELAY);
    localparam logic [CW-1:0]    REP_CNT    = CW'(REPEAT_PERIOD);
    localparam logic [WIDTH:0]   STEP_W     = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   YMIN_W     = (WIDTH+1)'(Y_MIN);
    localparam logic [WIDTH:0]   YMAX_W     = (WIDTH+1)'(Y_MAX);
    localparam logic [WIDTH-1:0] YMIN_N     = WIDTH'(Y_MIN);
    localparam logic [WIDTH-1:0] YMAX_N     = WIDTH'(Y_MAX);
    localparam logic [WIDTH-1:0] YINIT_N    = WIDTH'(Y_INIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    state_t           r_state;
    dir_t             r_dir;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_y;
    logic             r_moving;
    logic             r_at_limit;

    logic [WIDTH-1:0] w_y_up;
    logic [WIDTH-1:0] w_y_down;
    logic [WIDTH-1:0] w_y_same;
    logic [WIDTH-1:0] w_y_opp;
    logic [WIDTH-1:0] w_y_press;
    logic             w_active_level;
    logic             w_opp_press;
    logic             w_one_press;
    dir_t             w_press_dir;
    dir_t             w_opp_dir;
    logic [CW-1:0]    w_cnt_inc;

    // Step arithmetic is done one bit wider than the position so that
    // neither the subtraction nor the addition can wrap before clamping.
    function automatic logic [WIDTH-1:0] f_step_up(input logic [WIDTH-1:0] y);
        logic [WIDTH:0] y_w;
        logic [WIDTH:0] diff;
        y_w  = {1'b0, y};
        diff = y_w - STEP_W;
        if (y_w < (YMIN_W + STEP_W)) begin
            return YMIN_N;
        end
        return diff[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] f_step_down(input logic [WIDTH-1:0] y);
        logic [WIDTH:0] sum;
        sum = {1'b0, y} + STEP_W;
        if (sum > YMAX_W) begin
            return YMAX_N;
        end
        return sum[WIDTH-1:0];
    endfunction

    function automatic logic f_at_limit(input logic [WIDTH-1:0] y);
        return (y == YMIN_N) || (y == YMAX_N);
    endfunction

    always_comb begin
        w_y_up         = f_step_up(r_y);
        w_y_down       = f_step_down(r_y);
        w_y_same       = (r_dir == DIR_UP) ? w_y_up : w_y_down;
        w_y_opp        = (r_dir == DIR_UP) ? w_y_down : w_y_up;
        w_press_dir    = bus.up_press_in ? DIR_UP : DIR_DOWN;
        w_y_press      = bus.up_press_in ? w_y_up : w_y_down;
        w_one_press    = bus.up_press_in ^ bus.down_press_in;
        w_active_level = (r_dir == DIR_UP) ? bus.up_level_in : bus.down_level_in;
        w_opp_press    = (r_dir == DIR_UP) ? bus.down_press_in : bus.up_press_in;
        w_opp_dir      = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
        w_cnt_inc      = r_cnt + CW'(1);
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state    <= ST_IDLE;
            r_dir      <= DIR_UP;
            r_cnt      <= '0;
            r_y        <= YINIT_N;
            r_moving   <= 1'b0;
            r_at_limit <= f_at_limit(YINIT_N);
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Simultaneous presses cancel each other.
                    if (w_one_press) begin
                        r_dir      <= w_press_dir;
                        r_cnt      <= '0;
                        r_y        <= w_y_press;
                        r_at_limit <= f_at_limit(w_y_press);
                        r_state    <= ST_HOLD;
                        r_moving   <= 1'b1;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!w_active_level) begin
                        r_state  <= ST_IDLE;
                        r_moving <= 1'b0;
                    end else if (w_opp_press) begin
                        // Last pressed wins; a tick in this cycle is dropped.
                        r_dir      <= w_opp_dir;
                        r_cnt      <= '0;
                        r_y        <= w_y_opp;
                        r_at_limit <= f_at_limit(w_y_opp);
                        r_state    <= ST_HOLD;
                    end else if (bus.frame_tick_in) begin
                        if (w_cnt_inc == ((r_state == ST_HOLD) ? HOLD_CNT : REP_CNT)) begin
                            r_cnt      <= '0;
                            r_y        <= w_y_same;
                            r_at_limit <= f_at_limit(w_y_same);
                            r_state    <= ST_REPEAT;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_moving <= 1'b0;
                end
            endcase
        end
    end

    assign bus.paddle_y_out = r_y;
    assign bus.moving_out   = r_moving;
    assign bus.at_limit_out = r_at_limit;
endmodule

// File: tb/tb_paddle_controller.sv
// tb_paddle_controller
//   Directed bench for paddle_controller with default parameters: a table of
//   single-cycle vectors plus hand-written multi-cycle sequences for
//   auto-repeat, counter restart, saturation and reset during a hold.
module tb_paddle_controller;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    paddle_controller_if #(.WIDTH(10)) bus ();

    paddle_controller #(
        .WIDTH        (10),
        .Y_MIN        (0),
        .Y_MAX        (400),
        .Y_INIT       (200),
        .STEP         (4),
        .HOLD_DELAY   (30),
        .REPEAT_PERIOD(2)
    ) dut (
        .clock_in(clk),
        .reset_in(rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       tick;
        logic       up_p;
        logic       up_l;
        logic       dn_p;
        logic       dn_l;
        logic [9:0] y;
        logic       mov;
        logic       lim;
        string      name;
    } vec_t;

    vec_t vecs[15];

    // One clock cycle: drive inputs, take the edge, settle #1 after it.
    task automatic cyc(input logic r, input logic t, input logic upp, input logic upl,
                       input logic dnp, input logic dnl);
        rst               = r;
        bus.frame_tick_in = t;
        bus.up_press_in   = upp;
        bus.up_level_in   = upl;
        bus.down_press_in = dnp;
        bus.down_level_in = dnl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [9:0] ey, input logic em, input logic el);
        checks++;
        if (bus.paddle_y_out !== ey || bus.moving_out !== em || bus.at_limit_out !== el) begin
            failures++;
            $display("FAIL %s: got y=%0d moving=%b limit=%b, expected y=%0d moving=%b limit=%b",
                     name, bus.paddle_y_out, bus.moving_out, bus.at_limit_out, ey, em, el);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Table: each row is one cycle; expected values are after that edge.
        //            rst  tick up_p up_l dn_p dn_l   y    mov  lim
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 10'd200,1'b0,1'b0, "t_reset"};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 10'd200,1'b0,1'b0, "t_idle"};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 10'd196,1'b1,1'b0, "t_up_press"};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 10'd196,1'b1,1'b0, "t_up_hold_tick"};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 10'd196,1'b0,1'b0, "t_up_release"};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 10'd196,1'b0,1'b0, "t_idle_tick"};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1, 10'd196,1'b0,1'b0, "t_both_press"};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 10'd196,1'b0,1'b0, "t_both_held"};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 10'd192,1'b1,1'b0, "t_up_press2"};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b1, 10'd196,1'b1,1'b0, "t_opp_press_tick"};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 10'd196,1'b0,1'b0, "t_active_release"};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 10'd196,1'b0,1'b0, "t_no_resume"};
        vecs[12] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 10'd200,1'b1,1'b0, "t_dn_press_tick"};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 10'd200,1'b1,1'b0, "t_same_press"};
        vecs[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 10'd200,1'b0,1'b0, "t_release_tick"};

        // Reset then a long idle stretch.
        cyc(1, 0, 0, 0, 0, 0);
        chk("reset", 10'd200, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("idle100", 10'd200, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].rst, vecs[i].tick, vecs[i].up_p, vecs[i].up_l, vecs[i].dn_p, vecs[i].dn_l);
            chk(vecs[i].name, vecs[i].y, vecs[i].mov, vecs[i].lim);
        end

        // Hold down for 36 ticks; a tick in the press cycle is not counted.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 1);
        chk("dn_press", 10'd204, 1'b1, 1'b0);
        for (int t = 1; t <= 36; t++) begin
            cyc(0, 1, 0, 0, 0, 1);
            if (t == 29) chk("dn_tick29", 10'd204, 1'b1, 1'b0);
            if (t == 30) chk("dn_tick30", 10'd208, 1'b1, 1'b0);
            if (t == 31) chk("dn_tick31", 10'd208, 1'b1, 1'b0);
            if (t == 32) chk("dn_tick32", 10'd212, 1'b1, 1'b0);
            if (t == 36) chk("dn_tick36", 10'd220, 1'b1, 1'b0);
        end
        // Reset while in REPEAT with down still held.
        cyc(1, 1, 0, 0, 0, 1);
        chk("reset_mid_hold", 10'd200, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, 0, 1);
        chk("held_no_pulse", 10'd200, 1'b0, 1'b0);

        // Opposite press restarts the hold counter.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        chk("up_press_r", 10'd196, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 1, 0, 0);
        chk("up_20ticks", 10'd196, 1'b1, 1'b0);
        cyc(0, 0, 0, 1, 1, 1);
        chk("opp_press", 10'd200, 1'b1, 1'b0);
        for (int i = 0; i < 29; i++) cyc(0, 1, 0, 1, 0, 1);
        chk("restart_29", 10'd200, 1'b1, 1'b0);
        cyc(0, 1, 0, 1, 0, 1);
        chk("restart_30", 10'd204, 1'b1, 1'b0);

        // Saturation at Y_MIN.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 1, 0, 0);
        chk("lim_first_rep", 10'd192, 1'b1, 1'b0);
        for (int i = 0; i < 92; i++) cyc(0, 1, 0, 1, 0, 0);
        chk("lim_at8", 10'd8, 1'b1, 1'b0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        chk("lim_at4", 10'd4, 1'b1, 1'b0);
        cyc(0, 1, 0, 1, 0, 0);
        chk("lim_mid", 10'd4, 1'b1, 1'b0);
        cyc(0, 1, 0, 1, 0, 0);
        chk("lim_at0", 10'd0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, 0, 0);
        chk("lim_stay0", 10'd0, 1'b1, 1'b1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lim_release", 10'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
